// File: rtl/trap_pkg.sv
// Shared types and constants for the illegal-instruction trap unit.
package trap_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FLUSH,
    REDIRECT,
    IN_TRAP,
    RETURN
  } trap_state_e;

  localparam int unsigned CAUSE_ILLEGAL_INSTR = 2;
  localparam int unsigned CAUSE_BREAKPOINT    = 3;

  localparam int unsigned ERR_OPC   = 0;
  localparam int unsigned ERR_F3    = 1;
  localparam int unsigned ERR_SHAMT = 2;

endpackage

// File: rtl/trap_cause_enc.sv
// Priority encoder: decode error vector to a one-hot class (opcode > funct3 > shamt).
module trap_cause_enc
  import trap_pkg::*;
(
  input  logic [2:0] id_error,
  output logic [2:0] err_class,
  output logic       any_err
);

  always_comb begin
    err_class = '0;
    if (id_error[ERR_OPC])        err_class[ERR_OPC]   = 1'b1;
    else if (id_error[ERR_F3])    err_class[ERR_F3]    = 1'b1;
    else if (id_error[ERR_SHAMT]) err_class[ERR_SHAMT] = 1'b1;
  end

  assign any_err = |id_error;

endmodule

// File: rtl/illegal_instr_trap.sv
// Illegal-instruction trap sequencer: latch CSRs, flush, redirect to handler, return on MRET.
// Optional saturating error counter enabled by `define TRAP_ERR_COUNT_EN.
module illegal_instr_trap
  import trap_pkg::*;
#(
  parameter int unsigned      XLEN          = 32,
  parameter logic [XLEN-1:0]  TRAP_VEC      = 'h0000_0100,
  parameter int unsigned      CAUSE_ILLEGAL = CAUSE_ILLEGAL_INSTR
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            id_valid,
  input  logic [XLEN-1:0] id_pc,
  input  logic [31:0]     id_instr,
  input  logic [2:0]      id_error,
  input  logic            id_mret,
  output logic            id_ready,
  output logic            flush,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc,
  input  logic            redirect_ack,
  output logic [XLEN-1:0] mepc,
  output logic [XLEN-1:0] mcause,
  output logic [XLEN-1:0] mtval,
  output logic [2:0]      err_class,
  output logic            trap_active,
`ifdef TRAP_ERR_COUNT_EN
  output logic [15:0]     err_count,
`endif
  output logic            double_fault
);

  trap_state_e state;
  logic [2:0]  cls;
  logic        any_err;
  logic        hit;

  trap_cause_enc u_enc (
    .id_error  (id_error),
    .err_class (cls),
    .any_err   (any_err)
  );

  assign hit = id_valid & any_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      id_ready       <= 1'b1;
      flush          <= 1'b0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
      mepc           <= '0;
      mcause         <= '0;
      mtval          <= '0;
      err_class      <= '0;
      trap_active    <= 1'b0;
      double_fault   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (hit) begin
            mepc      <= id_pc;
            mtval     <= XLEN'(id_instr);
            mcause    <= XLEN'(CAUSE_ILLEGAL);
            err_class <= cls;
            flush     <= 1'b1;
            id_ready  <= 1'b0;
            state     <= FLUSH;
          end
        end
        FLUSH: begin
          flush          <= 1'b0;
          redirect_valid <= 1'b1;
          redirect_pc    <= TRAP_VEC;
          state          <= REDIRECT;
        end
        REDIRECT: begin
          if (redirect_ack) begin
            redirect_valid <= 1'b0;
            trap_active    <= 1'b1;
            id_ready       <= 1'b1;
            state          <= IN_TRAP;
          end
        end
        IN_TRAP: begin
          // An error in the same slot as MRET takes precedence; the MRET is dropped.
          if (hit) begin
            double_fault <= 1'b1;
          end else if (id_valid && id_mret) begin
            flush          <= 1'b1;
            redirect_valid <= 1'b1;
            redirect_pc    <= mepc + XLEN'(4);
            id_ready       <= 1'b0;
            state          <= RETURN;
          end
        end
        RETURN: begin
          flush <= 1'b0;
          if (redirect_ack) begin
            redirect_valid <= 1'b0;
            trap_active    <= 1'b0;
            id_ready       <= 1'b1;
            state          <= IDLE;
          end
        end
        default: begin
          flush          <= 1'b0;
          redirect_valid <= 1'b0;
          trap_active    <= 1'b0;
          id_ready       <= 1'b1;
          state          <= IDLE;
        end
      endcase
    end
  end

`ifdef TRAP_ERR_COUNT_EN
  logic cnt_inc;
  assign cnt_inc = hit && ((state == IDLE) || (state == IN_TRAP));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_count <= '0;
    end else if (cnt_inc && (err_count != 16'hFFFF)) begin
      err_count <= err_count + 16'd1;
    end
  end
`endif

endmodule
